// File: rtl/div_serial.sv
// div_serial: restoring divider, 2N-bit dividend by N-bit divisor, one quotient bit per clock, MSB first.
// Build option DIV_SERIAL_OUT_EN enables the serial quotient port (q_bit/q_valid); otherwise both are tied low.
module div_serial #(
   parameter int N = 4
) (
   input  logic           Clk,
   input  logic           reset,
   input  logic           start,
   input  logic [2*N-1:0] dividend,
   input  logic [N-1:0]   divisor,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] quotient,
   output logic [N-1:0]   remainder,
   output logic           dbz,
   output logic           q_bit,
   output logic           q_valid
);

   localparam int CW = (2*N > 1) ? $clog2(2*N) : 1;
   localparam logic [CW-1:0] LAST = CW'(2*N-1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t         state_q;
   logic [CW-1:0]  count_q;
   logic [2*N-1:0] dvd_q;     // dividend, shifted left each iteration so bit 2N-1 is the next bit
   logic [N-1:0]   dvs_q;
   logic [N-1:0]   rem_q;
   logic [2*N-1:0] quo_q;
   logic           busy_q;
   logic           done_q;
   logic           dbz_q;

   logic [N:0]     r_shift;
   logic           qbit_d;
   logic [N-1:0]   rem_d;

   always_comb begin
      r_shift = {rem_q, dvd_q[2*N-1]};
      qbit_d  = (r_shift >= {1'b0, dvs_q});
      rem_d   = qbit_d ? N'(r_shift - {1'b0, dvs_q}) : r_shift[N-1:0];
   end

`ifdef DIV_SERIAL_OUT_EN
   logic q_bit_q;
   logic q_valid_q;
`endif

   always_ff @(posedge Clk) begin
      if (!reset) begin
         state_q <= IDLE;
         count_q <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
`ifdef DIV_SERIAL_OUT_EN
         q_bit_q   <= 1'b0;
         q_valid_q <= 1'b0;
`endif
      end else begin
`ifdef DIV_SERIAL_OUT_EN
         q_bit_q   <= 1'b0;
         q_valid_q <= 1'b0;
`endif
         case (state_q)
            IDLE: begin
               if (start) begin
                  dvd_q   <= dividend;
                  dvs_q   <= divisor;
                  rem_q   <= '0;
                  quo_q   <= '0;
                  count_q <= '0;
                  dbz_q   <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= (divisor == '0) ? DONE : RUN;
               end
            end
            RUN: begin
               rem_q   <= rem_d;
               quo_q   <= {quo_q[2*N-2:0], qbit_d};
               dvd_q   <= dvd_q << 1;
               count_q <= count_q + 1'b1;
`ifdef DIV_SERIAL_OUT_EN
               q_bit_q   <= qbit_d;
               q_valid_q <= 1'b1;
`endif
               if (count_q == LAST) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end
            end
            DONE: begin
               if (done_q) begin
                  done_q  <= 1'b0;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  // Divide-by-zero path: DONE entered straight from IDLE, results posted one edge later
                  done_q <= 1'b1;
                  dbz_q  <= 1'b1;
                  quo_q  <= '1;
                  rem_q  <= '0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign quotient  = quo_q;
   assign remainder = rem_q;
   assign dbz       = dbz_q;

`ifdef DIV_SERIAL_OUT_EN
   assign q_bit   = q_bit_q;
   assign q_valid = q_valid_q;
`else
   assign q_bit   = 1'b0;
   assign q_valid = 1'b0;
`endif

endmodule
